unary_sum_collector: RTL and testbench

- Downstream consumer of the mod-15 unary adder stage.
- During the adder's read phase it counts carry pulses on cin. During the write phase it counts the unary pulse train on din.
- It reconstructs the binary total (carries*MOD + residue) and presents it on a valid/ready output register to the binary-domain logic.
- It shares en and read_or_write with the adder, so both stages step in lockstep.

---
 rtl/unary_sum_collector_pkg.sv | 17 +
 rtl/unary_run_counter.sv | 47 ++++
 rtl/unary_sum_collector.sv | 138 +++++++++++++
 tb/tb_unary_sum_collector.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/unary_sum_collector_pkg.sv
// unary_sum_collector_pkg: shared constants and FSM state type for the unary adder / collector pair
package unary_sum_collector_pkg;

    // Modulus of the upstream unary adder; the largest legal residue is MOD-1.
    localparam int MOD_DEF     = 15;
    localparam int CARRY_W_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        ACCUM,
        SKIP,
        DRAIN,
        EMIT,
        WAIT
    } state_e;

endpackage

// File: rtl/unary_run_counter.sv
// unary_run_counter: counts the unary pulse run, clamps at MOD-1 and flags an over-long run
module unary_run_counter
    import unary_sum_collector_pkg::*;
#(
    parameter int MOD   = MOD_DEF,
    parameter int RUN_W = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [RUN_W-1:0] run_o,
    output logic             err_o
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MOD - 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;

    // Next run count: clear wins, otherwise increment with a clamp that raises the sticky error
    always_comb begin
        run_d = run_q;
        err_d = err_q;
        if (clr_i) begin
            run_d = '0;
        end else if (inc_i) begin
            if (run_q == RUN_MAX) err_d = 1'b1;
            else run_d = run_q + 1'b1;
        end
    end

    // Counter and sticky error registers; only reset clears the error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign run_o = run_q;
    assign err_o = err_q;

endmodule

// File: rtl/unary_sum_collector.sv
// unary_sum_collector: rebuilds carries*MOD + residue from the unary adder and holds it on a valid/ready register
module unary_sum_collector
    import unary_sum_collector_pkg::*;
#(
    parameter int MOD     = MOD_DEF,
    parameter int CARRY_W = CARRY_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              read_or_write,
    input  logic              din,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              drop,
    output logic              err
);

    localparam int RUN_W = $clog2(MOD);
    localparam int TOT_W = DATA_W + CARRY_W;
    localparam logic [CARRY_W-1:0] CARRY_MAX = '1;

    state_e             state_q, state_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic               sat_q, sat_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               res_ovf_q, res_ovf_d;
    logic               abort_q, abort_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;

    logic [RUN_W-1:0]   run_cnt;
    logic [TOT_W-1:0]   total;
    logic               fin, abort_now, carry_clr, carry_inc, load, in_emit;

    // A frame ends on din=0 in DRAIN, or early when read_or_write drops during SKIP/DRAIN
    assign fin = en && ((state_q == DRAIN && (!read_or_write || !din)) ||
                        (state_q == SKIP && !read_or_write));
    assign abort_now = fin && !read_or_write;
    assign total     = TOT_W'(carry_q) * TOT_W'(MOD) + TOT_W'(run_cnt);
    assign in_emit   = en && state_q == EMIT;
    assign load      = in_emit && (!valid_q || out_ready);

    // An aborted drain restarts the carry count with this cycle's cin, so EMIT must not wipe it
    assign carry_clr = (in_emit && !abort_q) || abort_now;
    assign carry_inc = en && cin && (state_q == ACCUM || abort_now);

    unary_run_counter #(
        .MOD  (MOD),
        .RUN_W(RUN_W)
    ) u_run (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(en && (state_q == SKIP || state_q == EMIT)),
        .inc_i(en && state_q == DRAIN && read_or_write && din),
        .run_o(run_cnt),
        .err_o(err)
    );

    // Phase sequencing: ACCUM -> SKIP -> DRAIN -> EMIT -> WAIT -> ACCUM, frozen while en is low
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ACCUM:   state_d = read_or_write ? SKIP : ACCUM;
                SKIP:    state_d = read_or_write ? DRAIN : EMIT;
                DRAIN:   state_d = fin ? EMIT : DRAIN;
                EMIT:    state_d = WAIT;
                WAIT:    state_d = read_or_write ? WAIT : ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Saturating carry counter plus a flag remembering that an increment was lost
    always_comb begin
        carry_d = carry_clr ? '0 : carry_q;
        sat_d   = carry_clr ? 1'b0 : sat_q;
        if (carry_inc) begin
            if (carry_d == CARRY_MAX) sat_d = 1'b1;
            else carry_d = carry_d + 1'b1;
        end
    end

    // Capture the frame result and its overflow flag when the frame ends
    always_comb begin
        res_d     = fin ? total[DATA_W-1:0] : res_q;
        res_ovf_d = fin ? ((total >> DATA_W) != '0) || sat_q : res_ovf_q;
        abort_d   = fin ? !read_or_write : abort_q;
    end

    // Output register: EMIT loads when free or draining this cycle, otherwise drop pulses; handshake ignores en
    always_comb begin
        valid_d = load ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
        data_d  = load ? res_q : data_q;
        ovf_d   = load ? res_ovf_q : ovf_q;
        drop_d  = in_emit && !load;
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            carry_q   <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            abort_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            abort_q   <= abort_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_unary_sum_collector.sv
// tb_unary_sum_collector: directed frames against hand-computed totals
module tb_unary_sum_collector;

    logic       clk = 1'b0;
    logic       rst_n, en, read_or_write, din, cin, out_ready;
    logic       out_valid, out_ovf, drop, err;
    logic [7:0] out_data;
    logic       last_drop;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    unary_sum_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .read_or_write(read_or_write),
        .din          (din),
        .cin          (cin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ovf      (out_ovf),
        .drop         (drop),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rw, input bit c, input bit d);
        read_or_write = rw;
        cin = c;
        din = d;
        tick();
    endtask

    // Read phase with `carries` cin pulses, final-read carry on the first rw=1 cycle,
    // SKIP driven with din=1 (must be ignored), `pulses` din pulses, then frame end
    task automatic frame(input int carries, input bit last_c, input int pulses, input int gap_at);
        step(0, 0, 0);
        for (int i = 0; i < carries; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        step(1, last_c, 0);
        step(1, 0, 1);
        for (int i = 0; i < pulses; i++) begin
            if (i == gap_at) begin
                en = 1'b0;
                repeat (3) step(1, 1, 1);
                en = 1'b1;
            end
            step(1, 0, 1);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        last_drop = drop;
        step(0, 0, 0);
    endtask

    task automatic consume(input string name, input logic [7:0] exp_data, input logic exp_ovf);
        total++; if (out_valid !== 1'b1) $display("FAIL %s_valid got %b want 1", name, out_valid); else passed++;
        total++; if (out_data !== exp_data) $display("FAIL %s_data got %0d want %0d", name, out_data, exp_data); else passed++;
        total++; if (out_ovf !== exp_ovf) $display("FAIL %s_ovf got %b want %b", name, out_ovf, exp_ovf); else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL %s_release got %b want 0", name, out_valid); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; read_or_write = 1'b0; din = 1'b0; cin = 1'b0; out_ready = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'd0) $display("FAIL reset_data got %0d want 0", out_data); else passed++;
        total++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", out_ovf); else passed++;
        total++; if (drop !== 1'b0) $display("FAIL reset_drop got %b want 0", drop); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        frame(0, 0, 9, -1);
        total++; if (last_drop !== 1'b0) $display("FAIL basic_drop got %b want 0", last_drop); else passed++;
        consume("basic", 8'd9, 1'b0);
    endtask

    task automatic test_carry();
        frame(1, 0, 5, -1);
        consume("carry", 8'd20, 1'b0);
        frame(0, 1, 0, -1);
        consume("carry_last", 8'd15, 1'b0);
    endtask

    task automatic test_zero();
        frame(0, 0, 0, -1);
        consume("zero", 8'd0, 1'b0);
    endtask

    task automatic test_boundaries();
        frame(0, 0, 14, -1);
        total++; if (err !== 1'b0) $display("FAIL max_residue_err got %b want 0", err); else passed++;
        consume("max_residue", 8'd14, 1'b0);
        frame(16, 0, 2, -1);
        consume("carry_sat", 8'd227, 1'b1);
    endtask

    task automatic test_back_to_back();
        frame(0, 0, 3, -1);
        total++; if (last_drop !== 1'b0) $display("FAIL b2b_first_drop got %b want 0", last_drop); else passed++;
        frame(0, 0, 7, -1);
        total++; if (last_drop !== 1'b1) $display("FAIL b2b_second_drop got %b want 1", last_drop); else passed++;
        total++; if (drop !== 1'b0) $display("FAIL b2b_drop_width got %b want 0", drop); else passed++;
        consume("b2b_held", 8'd3, 1'b0);
    endtask

    task automatic test_en_freeze();
        frame(0, 0, 6, 3);
        total++; if (out_data !== 8'd6) $display("FAIL freeze_data got %0d want 6", out_data); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL freeze_valid got %b want 1", out_valid); else passed++;
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        en = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL freeze_handshake got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_err();
        frame(0, 0, 16, -1);
        total++; if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else passed++;
        total++; if (out_data !== 8'd14) $display("FAIL err_clamp got %0d want 14", out_data); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL err_valid got %b want 1", out_valid); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'd0) $display("FAIL midrst_data got %0d want 0", out_data); else passed++;
        total++; if (err !== 1'b0) $display("FAIL midrst_err got %b want 0", err); else passed++;
        read_or_write = 1'b0; din = 1'b0; cin = 1'b0;
        tick();
        rst_n = 1'b1;
        frame(0, 0, 4, -1);
        consume("post_reset", 8'd4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_boundaries();
        test_back_to_back();
        test_en_freeze();
        test_err();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
